// File: rtl/isp_frame_ctrl_pkg.sv
// Shared types and constants for the ISP frame sequencer.
package isp_frame_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StActive = 2'd1,
        StDrain  = 2'd2
    } state_e;

    localparam logic [1:0] MODE_RAW   = 2'd0;
    localparam logic [1:0] MODE_GRAY  = 2'd1;
    localparam logic [1:0] MODE_SOBEL = 2'd2;
    localparam logic [1:0] MODE_MORPH = 2'd3;

    localparam int unsigned FRAME_CNT_W = 16;
    localparam int unsigned GAP_CNT_W   = 16;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/isp_frame_ctrl_if.sv
// Control/status bundle between the camera capture side (master) and the frame sequencer (slave).
interface isp_frame_ctrl_if #(
    parameter int unsigned H_PIXEL = 640,
    parameter int unsigned V_PIXEL = 480
);
    import isp_frame_ctrl_pkg::*;

    localparam int unsigned XW = cnt_width(H_PIXEL);
    localparam int unsigned YW = cnt_width(V_PIXEL);

    logic                   frame_start;
    logic                   wr_en;
    logic [1:0]             mode_req;
    logic                   mode_req_vld;
    logic                   err_clr;
    logic [1:0]             mode_active;
    logic                   isp_en;
    logic [XW-1:0]          pix_x;
    logic [YW-1:0]          pix_y;
    logic                   frame_done;
    logic [FRAME_CNT_W-1:0] frame_cnt;
    logic                   err_frame;
    logic                   err_timeout;

    modport master (
        output frame_start, wr_en, mode_req, mode_req_vld, err_clr,
        input  mode_active, isp_en, pix_x, pix_y, frame_done, frame_cnt, err_frame, err_timeout
    );

    modport slave (
        input  frame_start, wr_en, mode_req, mode_req_vld, err_clr,
        output mode_active, isp_en, pix_x, pix_y, frame_done, frame_cnt, err_frame, err_timeout
    );

endinterface

// File: rtl/isp_pix_cnt.sv
// Raster x/y position counter with synchronous clear and last-pixel flag.
module isp_pix_cnt
    import isp_frame_ctrl_pkg::*;
#(
    parameter int unsigned H_PIXEL = 640,
    parameter int unsigned V_PIXEL = 480,
    parameter int unsigned XW      = cnt_width(H_PIXEL),
    parameter int unsigned YW      = cnt_width(V_PIXEL)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          last_o
);

    localparam logic [XW-1:0] XMax = XW'(H_PIXEL - 1);
    localparam logic [YW-1:0] YMax = YW'(V_PIXEL - 1);

    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q <= '0;
            y_q <= '0;
        end else if (clr_i) begin
            x_q <= '0;
            y_q <= '0;
        end else if (inc_i) begin
            if (x_q == XMax) begin
                x_q <= '0;
                y_q <= (y_q == YMax) ? '0 : y_q + YW'(1);
            end else begin
                x_q <= x_q + XW'(1);
            end
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign last_o = (x_q == XMax) && (y_q == YMax);

endmodule

// File: rtl/isp_frame_ctrl.sv
// Frame-level sequencer for the ISP chain: pixel tracking, pipeline drain, frame-aligned mode switch.
// Optional wr_en gap watchdog is built when ISP_TIMEOUT_EN is defined.
module isp_frame_ctrl
    import isp_frame_ctrl_pkg::*;
#(
    parameter int unsigned H_PIXEL     = 640,
    parameter int unsigned V_PIXEL     = 480,
    parameter int unsigned DRAIN_CYC   = 1300,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    isp_frame_ctrl_if.slave ctrl_io
);

    localparam int unsigned XW = cnt_width(H_PIXEL);
    localparam int unsigned YW = cnt_width(V_PIXEL);
    localparam int unsigned DW = cnt_width(DRAIN_CYC);
    localparam logic [DW-1:0] DrainLoad = DW'(DRAIN_CYC - 1);

    if (DRAIN_CYC == 0 || TIMEOUT_CYC == 0) begin : g_param_chk
        $error("isp_frame_ctrl: DRAIN_CYC and TIMEOUT_CYC must be at least 1");
    end

    state_e                 state_q;
    logic [DW-1:0]          drain_q;
    logic [1:0]             mode_active_q, pend_q;
    logic                   pend_vld_q;
    logic                   isp_en_q, frame_done_q, err_frame_q;
    logic [FRAME_CNT_W-1:0] frame_cnt_q;

    logic          drain_end, apply, pix_clr, pix_inc, pix_last, timeout;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;

    always_comb begin
        // A frame_start during drain completes the frame early and restarts capture.
        drain_end = (state_q == StDrain) && ((drain_q == '0) || ctrl_io.frame_start);
        apply     = ((state_q == StIdle) && ctrl_io.frame_start) || drain_end;
        pix_clr   = ctrl_io.frame_start || timeout;
        pix_inc   = (state_q == StActive) && ctrl_io.wr_en && !ctrl_io.frame_start;
    end

    isp_pix_cnt #(
        .H_PIXEL (H_PIXEL),
        .V_PIXEL (V_PIXEL),
        .XW      (XW),
        .YW      (YW)
    ) u_pix_cnt (
        .clk_i  (sys_clk),
        .rst_ni (sys_rst_n),
        .clr_i  (pix_clr),
        .inc_i  (pix_inc),
        .x_o    (pix_x),
        .y_o    (pix_y),
        .last_o (pix_last)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= StIdle;
            drain_q       <= '0;
            mode_active_q <= MODE_RAW;
            pend_q        <= MODE_RAW;
            pend_vld_q    <= 1'b0;
            isp_en_q      <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_cnt_q   <= '0;
            err_frame_q   <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (ctrl_io.frame_start) begin
                        state_q  <= StActive;
                        isp_en_q <= 1'b1;
                    end
                end
                StActive: begin
                    if (timeout) begin
                        state_q  <= StIdle;
                        isp_en_q <= 1'b0;
                    end else if (pix_inc && pix_last) begin
                        state_q <= StDrain;
                        drain_q <= DrainLoad;
                    end
                end
                StDrain: begin
                    if (drain_end) begin
                        state_q  <= ctrl_io.frame_start ? StActive : StIdle;
                        isp_en_q <= ctrl_io.frame_start;
                    end else begin
                        drain_q <= drain_q - DW'(1);
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    isp_en_q <= 1'b0;
                end
            endcase

            if (drain_end) begin
                frame_done_q <= 1'b1;
                frame_cnt_q  <= frame_cnt_q + FRAME_CNT_W'(1);
            end

            if (apply && pend_vld_q) begin
                mode_active_q <= pend_q;
            end
            // A request landing on an apply cycle survives for the next boundary.
            if (ctrl_io.mode_req_vld) begin
                pend_q     <= ctrl_io.mode_req;
                pend_vld_q <= 1'b1;
            end else if (apply) begin
                pend_vld_q <= 1'b0;
            end

            if ((state_q == StActive) && ctrl_io.frame_start) begin
                err_frame_q <= 1'b1;
            end else if (ctrl_io.err_clr) begin
                err_frame_q <= 1'b0;
            end
        end
    end

`ifdef ISP_TIMEOUT_EN
    logic [GAP_CNT_W-1:0] gap_q;
    logic                 err_timeout_q;

    assign timeout = (state_q == StActive) && !ctrl_io.wr_en && !ctrl_io.frame_start &&
                     (gap_q == GAP_CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            gap_q         <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            if ((state_q != StActive) || ctrl_io.wr_en || ctrl_io.frame_start) begin
                gap_q <= '0;
            end else begin
                gap_q <= gap_q + GAP_CNT_W'(1);
            end
            if (timeout) begin
                err_timeout_q <= 1'b1;
            end else if (ctrl_io.err_clr) begin
                err_timeout_q <= 1'b0;
            end
        end
    end

    assign ctrl_io.err_timeout = err_timeout_q;
`else
    assign timeout             = 1'b0;
    assign ctrl_io.err_timeout = 1'b0;
`endif

    assign ctrl_io.mode_active = mode_active_q;
    assign ctrl_io.isp_en      = isp_en_q;
    assign ctrl_io.pix_x       = pix_x;
    assign ctrl_io.pix_y       = pix_y;
    assign ctrl_io.frame_done  = frame_done_q;
    assign ctrl_io.frame_cnt   = frame_cnt_q;
    assign ctrl_io.err_frame   = err_frame_q;

endmodule
